// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button synchronizers/edge detect, run/pause/lap/full FSM,
// and the TICK_DIV prescaler that produces the one-cycle counter step pulse.
`timescale 1ns/1ps
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_start_stop,
  input  logic btn_lap,
  input  logic btn_reset,
  input  logic at_max,
  output logic cnt_enable,
  output logic cnt_clear,
  output logic running,
  output logic display_hold,
  output logic full
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {IDLE, RUNNING, LAP, PAUSED, FULL} state_t;

  state_t        state, state_nxt;
  logic [2:0]    sync1, sync2, prev;   // bit order {reset, start_stop, lap}
  logic [2:0]    press;
  logic          ev_rst, ev_ss, ev_lap;
  logic [PW-1:0] presc, presc_nxt;
  logic          active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= {btn_reset, btn_start_stop, btn_lap};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign press  = sync2 & ~prev;
  assign ev_rst = press[2];
  assign ev_ss  = press[1];
  assign ev_lap = press[0];
  assign active = (state == RUNNING) || (state == LAP);

  // at_max outranks the buttons while counting; a reset event outranks everything.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (ev_ss) state_nxt = RUNNING;
      RUNNING: begin
        if (at_max)      state_nxt = FULL;
        else if (ev_ss)  state_nxt = PAUSED;
        else if (ev_lap) state_nxt = LAP;
      end
      LAP: begin
        if (at_max)      state_nxt = FULL;
        else if (ev_ss)  state_nxt = PAUSED;
        else if (ev_lap) state_nxt = RUNNING;
      end
      PAUSED:  if (ev_ss) state_nxt = RUNNING;
      FULL:    state_nxt = FULL;
      default: state_nxt = IDLE;
    endcase
    if (ev_rst) state_nxt = IDLE;
  end

  always_comb begin
    presc_nxt = presc;
    if (ev_rst || state == IDLE) begin
      presc_nxt = '0;
    end else if (active) begin
      presc_nxt = (presc == PMAX) ? '0 : presc + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      presc     <= '0;
      cnt_clear <= 1'b0;
    end else begin
      state     <= state_nxt;
      presc     <= presc_nxt;
      cnt_clear <= ev_rst;
    end
  end

  assign cnt_enable   = active && (presc == PMAX) && !at_max;
  assign running      = active;
  assign display_hold = (state == LAP);
  assign full         = (state == FULL);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed vector table, hand-written corner
// sequences and randomized button traffic against a rule-level reference model.
`timescale 1ns/1ps
module tb_stopwatch_ctrl;

  localparam int unsigned TD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic b_ss = 1'b0, b_lap = 1'b0, b_rst = 1'b0, am = 1'b0;
  logic cnt_enable, cnt_clear, running, display_hold, full;

  stopwatch_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_start_stop(b_ss), .btn_lap(b_lap), .btn_reset(b_rst), .at_max(am),
    .cnt_enable(cnt_enable), .cnt_clear(cnt_clear), .running(running),
    .display_hold(display_hold), .full(full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode flags, count of active cycles modulo TD, and the last three
  // sampled button levels ({reset, start_stop, lap}).
  bit          m_run, m_lap, m_pause, m_full, m_clr;
  int unsigned m_phase;
  bit [2:0]    h1, h2, h3;
  bit          seen_en;
  int unsigned since;

  typedef struct { logic [3:0] in; logic [4:0] exp; } vec_t;  // in={ss,lap,rst,am}
  vec_t tbl[$];

  function automatic void v(int n, logic [3:0] vin, logic [4:0] vexp);
    for (int i = 0; i < n; i++) tbl.push_back('{in: vin, exp: vexp});
  endfunction

  function automatic logic [4:0] obs();
    return {running, display_hold, full, cnt_clear, cnt_enable};
  endfunction

  function automatic logic [4:0] model_out();
    logic en;
    en = (m_run || m_lap) && (m_phase == TD - 1) && !am;
    return {m_run | m_lap, m_lap, m_full, m_clr, en};
  endfunction

  task automatic chk_v(input string name, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %b expected %b (run,hold,full,clr,en)", name, $time, got, exp);
    end
  endtask

  task automatic chk_n(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_lap = 0; m_pause = 0; m_full = 0; m_clr = 0; m_phase = 0;
    h1 = '0; h2 = '0; h3 = '0;
    seen_en = 0; since = 0;
  endtask

  task automatic model_edge();
    bit [2:0] ev;
    bit act;
    ev  = h2 & ~h3;
    act = m_run | m_lap;
    if (ev[2]) begin
      m_run = 0; m_lap = 0; m_pause = 0; m_full = 0; m_phase = 0; m_clr = 1;
    end else begin
      m_clr = 0;
      if (act) begin
        m_phase = (m_phase + 1) % TD;
        if (am) begin
          m_run = 0; m_lap = 0; m_full = 1;
        end else if (ev[1]) begin
          m_run = 0; m_lap = 0; m_pause = 1;
        end else if (ev[0]) begin
          m_run = ~m_run; m_lap = ~m_lap;
        end
      end else if (!m_full && ev[1]) begin
        m_pause = 0; m_run = 1;
      end
    end
    h3 = h2; h2 = h1; h1 = {b_rst, b_ss, b_lap};
  endtask

  // One clock: advance model on the edge, drive this cycle's inputs, compare, track cadence.
  task automatic cyc(input logic [3:0] vin);
    @(posedge clk);
    model_edge();
    #1;
    {b_ss, b_lap, b_rst, am} = vin;
    #1;
    chk_v("model", obs(), model_out());
    if (cnt_clear) begin
      seen_en = 0; since = 0;
    end
    if (running) since++;
    if (cnt_enable) begin
      chk_n("en_while_stopped", running, 1);
      if (seen_en) chk_n("step_cadence", since, TD);
      since = 0; seen_en = 1;
    end
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    chk_v("async_reset", obs(), 5'b00000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    bit found;
    logic s, l, r;

    v(3, 4'b1000, 5'b00000);  v(3, 4'b1000, 5'b10000);  v(1, 4'b1000, 5'b10001);
    v(3, 4'b1000, 5'b10000);  v(1, 4'b0000, 5'b10001);  v(3, 4'b0000, 5'b10000);
    v(1, 4'b0000, 5'b10001);  v(1, 4'b0100, 5'b10000);  v(2, 4'b0000, 5'b10000);
    v(1, 4'b0000, 5'b11001);  v(1, 4'b0000, 5'b11000);  v(1, 4'b0100, 5'b11000);
    v(1, 4'b0000, 5'b11000);  v(1, 4'b0000, 5'b11001);  v(1, 4'b0000, 5'b10000);
    v(1, 4'b1000, 5'b10000);  v(1, 4'b0000, 5'b10000);  v(1, 4'b0000, 5'b10001);
    v(1, 4'b0000, 5'b00000);  v(1, 4'b0100, 5'b00000);  v(3, 4'b0000, 5'b00000);
    v(1, 4'b1000, 5'b00000);  v(2, 4'b0000, 5'b00000);  v(3, 4'b0000, 5'b10000);
    v(1, 4'b0000, 5'b10001);  v(3, 4'b0000, 5'b10000);  v(1, 4'b0001, 5'b10000);
    v(1, 4'b1000, 5'b00100);  v(3, 4'b0000, 5'b00100);  v(1, 4'b0010, 5'b00100);
    v(2, 4'b0000, 5'b00100);  v(1, 4'b0000, 5'b00010);  v(1, 4'b0000, 5'b00000);
    v(1, 4'b1000, 5'b00000);  v(2, 4'b0000, 5'b00000);  v(2, 4'b0000, 5'b10000);
    v(1, 4'b1110, 5'b10000);  v(1, 4'b0000, 5'b10001);  v(1, 4'b0000, 5'b10000);
    v(1, 4'b0000, 5'b00010);  v(1, 4'b0000, 5'b00000);

    model_reset();
    #3;
    chk_v("reset_state", obs(), 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].in);
      chk_v($sformatf("vec%0d", i), obs(), tbl[i].exp);
    end

    // Pause with a partial step pending: the remaining steps complete after resume.
    cyc(4'b1000);
    repeat (4) cyc(4'b0000);
    cyc(4'b1000);
    repeat (22) cyc(4'b0000);
    cyc(4'b1000);
    n = 0; found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      cyc(4'b0000);
      if (running) n++;
      if (cnt_enable) found = 1;
    end
    chk_n("resume_found_step", int'(found), 1);
    chk_n("resume_steps", n, 3);

    // start_stop and lap in the same cycle from RUNNING: start_stop wins.
    cyc(4'b1100);
    repeat (3) cyc(4'b0000);
    chk_v("ss_lap_same_cycle", obs(), 5'b00000);

    // Async reset in LAP with prescaler at 2, then a fresh full-length first step.
    cyc(4'b1000);
    repeat (2) cyc(4'b0000);
    cyc(4'b0100);
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      cyc(4'b0000);
      if (m_lap && m_phase == 2) found = 1;
    end
    chk_n("reach_lap_phase2", int'(found), 1);
    async_reset();
    cyc(4'b1000);
    n = 0; found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      cyc(4'b0000);
      if (running) n++;
      if (cnt_enable) found = 1;
    end
    chk_n("post_reset_found_step", int'(found), 1);
    chk_n("post_reset_first_step", n, TD);

    // Randomized button traffic against the model.
    s = 0; l = 0; r = 0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 5) == 0)  s = ~s;
      if ($urandom_range(0, 5) == 0)  l = ~l;
      if ($urandom_range(0, 59) == 0) r = ~r;
      cyc({s, l, r, ($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0});
      if ($urandom_range(0, 399) == 0) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
